// File: rtl/prince_sbox_round_ctrl_if.sv
// prince_sbox_round_ctrl_if: randomness handshake between the PRNG and the
// masked PRINCE S-box round controller.
interface prince_sbox_round_ctrl_if #(
    parameter int RAND_W = 108
);
    logic              rnd_valid;
    logic              rnd_ready;
    logic [RAND_W-1:0] rnd_data;

    modport master (output rnd_valid, output rnd_data, input rnd_ready);
    modport slave  (input rnd_valid, input rnd_data, output rnd_ready);
endinterface

// File: rtl/prince_sbox_round_ctrl.sv
// prince_sbox_round_ctrl: round sequencer for the second-order masked PRINCE
// S-box (three shares, one register stage before compression). Fetches one
// fresh randomness word per round, sequences capture/commit and reports
// busy/done to the encryption FSM.
// Optional feature: define PRINCE_CTRL_ZERO_RAND_REJECT_EN to discard
// all-zero randomness words and raise the sticky rand_err flag.
module prince_sbox_round_ctrl #(
    parameter int ROUNDS   = 12,
    parameter int RAND_W   = 108,
    parameter int SBOX_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    prince_sbox_round_ctrl_if.slave    rnd,
    output logic [RAND_W-1:0]          r_out,
    output logic                       sel,
    output logic                       sbox_en,
    output logic                       state_load,
    output logic                       state_en,
    output logic [3:0]                 round_idx,
    output logic                       inv_phase,
    output logic                       busy,
    output logic                       done,
    output logic                       rand_err
);

    localparam int                 CNT_W      = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
    localparam logic [3:0]         LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [3:0]         HALF_ROUND = 4'(ROUNDS / 2);
    localparam logic [CNT_W-1:0]   WAIT_INIT  = CNT_W'(SBOX_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        ISSUE,
        WAIT,
        COMMIT,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [RAND_W-1:0]   r_out_q, r_out_d;
    logic                sel_q, sel_d;
    logic [3:0]          round_q, round_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                handshake;
    logic                word_ok;

    // The PRNG word is only taken while fetching; abort blocks the handshake.
    assign rnd.rnd_ready = (state_q == FETCH) & ~abort;
    assign handshake     = rnd.rnd_valid & rnd.rnd_ready;

`ifdef PRINCE_CTRL_ZERO_RAND_REJECT_EN
    assign word_ok = |rnd.rnd_data;
`else
    assign word_ok = 1'b1;
`endif

    // Next-state logic: round sequencing, randomness capture and abort override.
    always_comb begin
        state_d    = state_q;
        r_out_d    = r_out_q;
        sel_d      = sel_q;
        round_d    = round_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                round_d = 4'd0;
                sel_d   = 1'b0;
                state_d = FETCH;
            end
            FETCH: begin
                if (handshake && word_ok) begin
                    r_out_d = rnd.rnd_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = WAIT_INIT;
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == '0) state_d = COMMIT;
                else                  wait_cnt_d = wait_cnt_q - CNT_W'(1);
            end
            COMMIT: begin
                sel_d = ~sel_q;
                if (round_q == LAST_ROUND) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
            if (state_q != IDLE) begin
                r_out_d = '0;
                round_d = 4'd0;
                sel_d   = 1'b0;
            end
        end
    end

    // Controller registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            r_out_q    <= '0;
            sel_q      <= 1'b0;
            round_q    <= 4'd0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            r_out_q    <= r_out_d;
            sel_q      <= sel_d;
            round_q    <= round_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef PRINCE_CTRL_ZERO_RAND_REJECT_EN
    logic rand_err_q, rand_err_d;

    // Sticky flag for discarded all-zero words, cleared when a new run loads.
    always_comb begin
        rand_err_d = rand_err_q;
        if (state_q == LOAD)              rand_err_d = 1'b0;
        else if (handshake && !word_ok)   rand_err_d = 1'b1;
    end

    // Rejected-randomness flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rand_err_q <= 1'b0;
        else        rand_err_q <= rand_err_d;
    end

    assign rand_err = rand_err_q;
`else
    assign rand_err = 1'b0;
`endif

    assign r_out      = r_out_q;
    assign sel        = sel_q;
    assign round_idx  = round_q;
    assign inv_phase  = (round_q >= HALF_ROUND);
    assign state_load = (state_q == LOAD);
    assign sbox_en    = (state_q == ISSUE);
    assign state_en   = (state_q == COMMIT);
    assign done       = (state_q == DONE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_prince_sbox_round_ctrl.sv
// tb_prince_sbox_round_ctrl: self-checking bench for the masked PRINCE S-box
// round controller, using a cycle-level behavioural model plus directed
// latency/ordering checks and randomized traffic.
module tb_prince_sbox_round_ctrl;

    localparam int ROUNDS   = 12;
    localparam int RAND_W   = 108;
    localparam int SBOX_LAT = 1;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              rnd_valid = 1'b0;
    logic [RAND_W-1:0] rnd_data  = '0;

    logic [RAND_W-1:0] r_out;
    logic              sel, sbox_en, state_load, state_en;
    logic [3:0]        round_idx;
    logic              inv_phase, busy, done, rand_err;
    logic              rnd_ready;

    int vectors     = 0;
    int miscompares = 0;

    prince_sbox_round_ctrl_if #(.RAND_W(RAND_W)) rnd_if ();

    assign rnd_if.rnd_valid = rnd_valid;
    assign rnd_if.rnd_data  = rnd_data;
    assign rnd_ready        = rnd_if.rnd_ready;

    prince_sbox_round_ctrl #(
        .ROUNDS   (ROUNDS),
        .RAND_W   (RAND_W),
        .SBOX_LAT (SBOX_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .rnd        (rnd_if),
        .r_out      (r_out),
        .sel        (sel),
        .sbox_en    (sbox_en),
        .state_load (state_load),
        .state_en   (state_en),
        .round_idx  (round_idx),
        .inv_phase  (inv_phase),
        .busy       (busy),
        .done       (done),
        .rand_err   (rand_err)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a run is a LOAD cycle followed by ROUNDS rounds, each
    // round being a fetch step of any length, one issue step, SBOX_LAT wait
    // steps and one commit step; a done cycle follows the last commit.
    bit                m_active;
    bit                m_done;
    int                m_step;
    int                m_commits;
    logic [RAND_W-1:0] m_r;
    bit                m_rerr;
    int                exp_round;

    // Advance the model on every clock edge from the bench's own inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active  <= 1'b0;
            m_done    <= 1'b0;
            m_step    <= 0;
            m_commits <= 0;
            m_r       <= '0;
            m_rerr    <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
            if (abort) begin
                m_r       <= '0;
                m_commits <= 0;
            end
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active <= 1'b1;
                m_step   <= -1;
            end
        end else if (abort) begin
            m_active  <= 1'b0;
            m_r       <= '0;
            m_commits <= 0;
        end else if (m_step == -1) begin
            m_commits <= 0;
            m_rerr    <= 1'b0;
            m_step    <= 0;
        end else if (m_step == 0) begin
            if (rnd_valid) begin
`ifdef PRINCE_CTRL_ZERO_RAND_REJECT_EN
                if (rnd_data == '0) begin
                    m_rerr <= 1'b1;
                end else begin
                    m_r    <= rnd_data;
                    m_step <= 1;
                end
`else
                m_r    <= rnd_data;
                m_step <= 1;
`endif
            end
        end else if (m_step < SBOX_LAT + 2) begin
            m_step <= m_step + 1;
        end else begin
            m_commits <= m_commits + 1;
            if (m_commits == ROUNDS - 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end else begin
                m_step <= 0;
            end
        end
    end

    // Compare every DUT output against the model in the middle of each cycle.
    always @(negedge clk) begin
        exp_round = (m_commits > ROUNDS - 1) ? ROUNDS - 1 : m_commits;
        checkOutput("busy",       128'(busy),       128'(m_active | m_done));
        checkOutput("state_load", 128'(state_load), 128'(m_active && m_step == -1));
        checkOutput("rnd_ready",  128'(rnd_ready),  128'(m_active && m_step == 0 && !abort));
        checkOutput("sbox_en",    128'(sbox_en),    128'(m_active && m_step == 1));
        checkOutput("state_en",   128'(state_en),   128'(m_active && m_step == SBOX_LAT + 2));
        checkOutput("done",       128'(done),       128'(m_done));
        checkOutput("round_idx",  128'(round_idx),  128'(exp_round));
        checkOutput("sel",        128'(sel),        128'(m_commits % 2));
        checkOutput("inv_phase",  128'(inv_phase),  128'(exp_round >= ROUNDS / 2));
        checkOutput("r_out",      128'(r_out),      128'(m_r));
        checkOutput("rand_err",   128'(rand_err),   128'(m_rerr));
    end

    // One full encryption pass with optional stalls, busy starts, abort and a
    // leading all-zero word; reports the done cycle relative to start.
    task automatic run_pass(input int stall, input bit busy_starts, input int abort_round,
                            input bit zero_first, output int done_cycle,
                            output int sbox_cnt, output int sten_cnt);
        int                n;
        int                wait_cnt;
        int                taken;
        bit                pending_abort;
        bit                fire_abort;
        bit                aborted;
        bit                finished;
        bit                obs_sbox;
        bit                obs_ready;
        logic [RAND_W-1:0] exp_word;
        done_cycle    = -1;
        sbox_cnt      = 0;
        sten_cnt      = 0;
        wait_cnt      = 0;
        taken         = 0;
        pending_abort = 1'b0;
        aborted       = 1'b0;
        finished      = 1'b0;
        @(negedge clk);
        #1;
        start     = 1'b1;
        abort     = 1'b0;
        rnd_valid = 1'b0;
        rnd_data  = '0;
        n = 0;
        while (n < 1000 && !finished) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            fire_abort    = pending_abort;
            pending_abort = 1'b0;
            obs_sbox      = sbox_en;
            obs_ready     = rnd_ready;
            if (aborted) begin
                checkOutput("abort_busy",  128'(busy),      128'(0));
                checkOutput("abort_r_out", 128'(r_out),     128'(0));
                checkOutput("abort_round", 128'(round_idx), 128'(0));
                finished = 1'b1;
            end else if (done) begin
                done_cycle = n;
                finished   = 1'b1;
            end else begin
                if (obs_sbox) begin
`ifdef PRINCE_CTRL_ZERO_RAND_REJECT_EN
                    exp_word = RAND_W'(32'h5A + sbox_cnt);
`else
                    if (zero_first) exp_word = (sbox_cnt == 0) ? '0 : RAND_W'(32'h5A + sbox_cnt - 1);
                    else            exp_word = RAND_W'(32'h5A + sbox_cnt);
`endif
                    checkOutput("round_word", 128'(r_out),     128'(exp_word));
                    checkOutput("round_sel",  128'(sel),       128'(sbox_cnt % 2));
                    checkOutput("round_inv",  128'(inv_phase), 128'(sbox_cnt >= ROUNDS / 2));
                    if (sbox_cnt == abort_round) pending_abort = 1'b1;
                    sbox_cnt++;
                end
                if (state_en) sten_cnt++;
            end
            #1;
            start     = busy_starts && obs_sbox && (sbox_cnt == 3 || sbox_cnt == 8);
            abort     = fire_abort && !finished;
            rnd_valid = 1'b0;
            if (fire_abort) aborted = 1'b1;
            if (obs_ready && !finished && !fire_abort) begin
                if (wait_cnt < stall) begin
                    wait_cnt++;
                end else begin
                    rnd_valid = 1'b1;
                    rnd_data  = (zero_first && taken == 0) ? '0
                                : RAND_W'(32'h5A + taken - (zero_first ? 1 : 0));
                    wait_cnt  = 0;
                    taken++;
                end
            end
        end
        if (!finished) checkOutput("pass_timeout", 128'(0), 128'(1));
        start     = 1'b0;
        abort     = 1'b0;
        rnd_valid = 1'b0;
    endtask

    // Randomized traffic: starts, rare aborts, bursty valid and occasional zero words.
    task automatic applyStimulus(input int cycles);
        logic [127:0] wide;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            wide      = {$urandom(), $urandom(), $urandom(), $urandom()};
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 199) == 0);
            rnd_valid = $urandom_range(0, 1) == 1;
            rnd_data  = ($urandom_range(0, 9) == 0) ? '0 : wide[RAND_W-1:0];
        end
        @(negedge clk);
        #1;
        start     = 1'b0;
        abort     = 1'b1;
        rnd_valid = 1'b0;
        @(negedge clk);
        #1;
        abort = 1'b0;
    endtask

    // Drop reset between edges during a commit and check outputs clear at once.
    task automatic reset_mid_commit();
        bit hit;
        hit = 1'b0;
        @(negedge clk);
        #1;
        start     = 1'b1;
        rnd_valid = 1'b1;
        rnd_data  = RAND_W'(32'hC3);
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (state_en && round_idx == 4'd2) hit = 1'b1;
            #1;
            start = 1'b0;
        end
        if (!hit) begin
            checkOutput("reset_reach_commit", 128'(0), 128'(1));
        end else begin
            rst_n = 1'b0;
            #1;
            checkOutput("areset_busy",     128'(busy),      128'(0));
            checkOutput("areset_state_en", 128'(state_en),  128'(0));
            checkOutput("areset_r_out",    128'(r_out),     128'(0));
            checkOutput("areset_round",    128'(round_idx), 128'(0));
            checkOutput("areset_sel",      128'(sel),       128'(0));
        end
        rnd_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Overall watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int done_cycle, sbox_cnt, sten_cnt;
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("reset_busy",  128'(busy),      128'(0));
        checkOutput("reset_r_out", 128'(r_out),     128'(0));
        checkOutput("reset_round", 128'(round_idx), 128'(0));
        checkOutput("reset_sel",   128'(sel),       128'(0));
        checkOutput("reset_done",  128'(done),      128'(0));
        rst_n = 1'b1;

        run_pass(0, 1'b0, -1, 1'b0, done_cycle, sbox_cnt, sten_cnt);
        checkOutput("nominal_latency", 128'(done_cycle), 128'(50));
        checkOutput("nominal_sbox",    128'(sbox_cnt),   128'(12));
        checkOutput("nominal_commits", 128'(sten_cnt),   128'(12));

        run_pass(5, 1'b0, -1, 1'b0, done_cycle, sbox_cnt, sten_cnt);
        checkOutput("stall_latency", 128'(done_cycle), 128'(110));
        checkOutput("stall_sbox",    128'(sbox_cnt),   128'(12));

        run_pass(0, 1'b0, 3, 1'b0, done_cycle, sbox_cnt, sten_cnt);
        checkOutput("abort_no_done", 128'(done_cycle), 128'(-1));
        checkOutput("abort_sbox",    128'(sbox_cnt),   128'(4));

        run_pass(0, 1'b0, -1, 1'b0, done_cycle, sbox_cnt, sten_cnt);
        checkOutput("after_abort_latency", 128'(done_cycle), 128'(50));

        run_pass(0, 1'b1, -1, 1'b0, done_cycle, sbox_cnt, sten_cnt);
        checkOutput("busy_start_latency", 128'(done_cycle), 128'(50));
        checkOutput("busy_start_sbox",    128'(sbox_cnt),   128'(12));

        run_pass(0, 1'b0, -1, 1'b1, done_cycle, sbox_cnt, sten_cnt);
`ifdef PRINCE_CTRL_ZERO_RAND_REJECT_EN
        checkOutput("zero_word_latency", 128'(done_cycle), 128'(51));
        checkOutput("zero_word_err",     128'(rand_err),   128'(1));
`else
        checkOutput("zero_word_latency", 128'(done_cycle), 128'(50));
        checkOutput("zero_word_err",     128'(rand_err),   128'(0));
`endif

        reset_mid_commit();

        applyStimulus(3000);

        run_pass(0, 1'b0, -1, 1'b0, done_cycle, sbox_cnt, sten_cnt);
        checkOutput("final_latency", 128'(done_cycle), 128'(50));

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prince_sbox_round_ctrl.md
Name: prince_sbox_round_ctrl

Overview:
Round sequencer for the second-order masked PRINCE S-box datapath (three shares, one register stage between component functions and compression).
- Fetches one fresh randomness word per round from the PRNG over a valid/ready handshake.
- Drives the S-box capture enable, the randomness bus and the `sel` toggle, then commits the compressed shares to the state register.
- Tracks the round index and the forward/inverse phase, and reports start/busy/done to the top-level encryption FSM.

Parameters:
- ROUNDS, 12, number of S-box rounds per encryption (even, 2..14)
- RAND_W, 108, width of the fresh-randomness word per round
- SBOX_LAT, 1, cycles between S-box capture and valid compressed output (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin encryption; sampled only in IDLE
- abort  in  1  abandon the current run; any state returns to IDLE
- rnd_valid  in  1  PRNG word available
- rnd_data  in  RAND_W  PRNG word
- rnd_ready  out  1  controller accepts the word; combinational = (state==FETCH) & ~abort
- r_out  out  RAND_W  registered randomness to the S-box `r` input
- sel  out  1  S-box randomness-mux select
- sbox_en  out  1  S-box pipeline register capture enable
- state_load  out  1  load plaintext shares into the state register
- state_en  out  1  write S-box output shares into the state register
- round_idx  out  4  current round, 0..ROUNDS-1
- inv_phase  out  1  1 when round_idx >= ROUNDS/2 (inverse S-box rounds)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at completion
- rand_err  out  1  sticky rejected-randomness flag (optional feature)

Behaviour:
Reset:
- State is IDLE.
- All outputs are 0, including r_out=0, sel=0 and round_idx=0.

FSM states: IDLE, LOAD, FETCH, ISSUE, WAIT, COMMIT, DONE.
- IDLE: start=1 -> LOAD.
- LOAD: one cycle. state_load=1, round_idx<=0, sel<=0 -> FETCH.
- FETCH: rnd_ready=1. On rnd_valid&rnd_ready, r_out<=rnd_data -> ISSUE. Otherwise stay in FETCH with no timeout.
- ISSUE: one cycle, sbox_en=1 -> WAIT.
- WAIT: SBOX_LAT cycles, counted by an internal counter loaded on entry -> COMMIT.
- COMMIT: one cycle, state_en=1, and sel toggles at the end of the cycle.
  - If round_idx==ROUNDS-1 -> DONE.
  - Else round_idx<=round_idx+1 -> FETCH.
- DONE: done=1 for one cycle -> IDLE. round_idx holds its final value until the next LOAD.

Output stability:
- r_out and sel are constant from ISSUE through COMMIT of a round.
- r_out never changes outside a FETCH handshake, an abort, or reset.

Latency:
- With rnd_valid held high and start sampled in cycle 0, done is high in cycle 2+ROUNDS*(3+SBOX_LAT).
- Default parameters: cycle 50.

Boundary conditions:
- start while busy is ignored.
- start and abort together in IDLE: abort wins, stay in IDLE.
- abort in any non-IDLE state:
  - IDLE next edge, no done pulse.
  - r_out<=0, round_idx<=0, sel<=0.
  - No handshake completes in that cycle.
- rnd_valid outside FETCH: ignored, rnd_ready=0.
- round_idx must never reach ROUNDS. The compare is done on the full 4-bit value.
- Reset asserted mid-run: immediate return to reset values. The state register contents are the owner's concern.

Optional Feature:
PRINCE_CTRL_ZERO_RAND_REJECT_EN
- Defined:
  - In FETCH, an accepted word equal to all zeros completes the handshake but is discarded.
  - The FSM stays in FETCH and r_out is unchanged.
  - rand_err<=1 and stays set until the next LOAD or reset.
- Undefined: every word is accepted and rand_err is tied to 0.

Test Plan:
- Nominal run: reset, start pulse, rnd_valid=1 with incrementing rnd_data -> done in cycle 50; 12 state_en pulses; r_out in round k equals the k-th word; sel sequence 0,1,0,1...; inv_phase=1 for rounds 6..11.
- Backpressure: rnd_valid low for 5 cycles at each FETCH -> FSM stalls; done delayed by exactly 60 cycles; sbox_en count stays 12.
- Abort: abort in WAIT of round 3 -> IDLE next cycle, no done, r_out=0; a following start runs a full 50-cycle pass.
- Start while busy: start pulses in rounds 2 and 7 -> no effect; single done at cycle 50.
- Async reset: assert rst_n=0 mid-COMMIT between edges -> outputs 0 immediately, without waiting for a clock edge; busy=0.
- With PRINCE_CTRL_ZERO_RAND_REJECT_EN: feed 0 then 0x5A in round 0 -> rand_err=1, r_out=0x5A, total latency +1 cycle. Without the macro: r_out=0 is accepted and rand_err=0.
